// File: rtl/mem_responder.sv
// mem_responder: bus responder at the far end of the CPU memory port.
//
// Serves instruction fetch and load/store requests over a req/ready handshake.
// Each request is accepted in idle, waits WAIT_STATES cycles, performs its
// access on a single edge and then answers with a one-cycle ready pulse.
// Word addresses decode to on-chip RAM, a small MMIO bank or an unmapped
// error region.
//
// Parameters:
//   ADDR_WIDTH   RAM word-address bits (depth 2**ADDR_WIDTH x 32).
//   WAIT_STATES  Cycles between acceptance and access, 0..15.
//   UNMAP_DATA   Read data returned for unmapped addresses.
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   synchronous active-high reset
//   req      in   request, held until ready is seen
//   wren     in   1 = write, 0 = read
//   address  in   30-bit word address
//   data     in   write data
//   q        out  read data, valid while ready = 1
//   ready    out  one-cycle completion pulse
//   err      out  pulses with ready for unmapped accesses
//   led      out  LED register bits [7:0]
//
// MMIO map (address[29:28] = 2'b11, register chosen by address[1:0]):
//   0 cycle counter (read-only), 1 LED (RW), 2 scratch (RW), 3 reserved.

module mem_responder #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] UNMAP_DATA  = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wren,
  input  logic [29:0] address,
  input  logic [31:0] data,
  output logic [31:0] q,
  output logic        ready,
  output logic        err,
  output logic [7:0]  led
);

  localparam int unsigned RamDepth = 2 ** ADDR_WIDTH;
  // The wait counter is 4 bits wide; WAIT_STATES above 15 is not supported.
  localparam logic [3:0]  WaitLoad = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StAccess,
    StResp
  } state_e;

  state_e state_q, state_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;

  // Request fields captured at acceptance and frozen until the response.
  logic [29:0] addr_q;
  logic        wren_q;
  logic [31:0] wdata_q;

  logic [31:0] cycle_cnt_q;
  logic [31:0] led_reg_q;
  logic [31:0] scratch_q;
  logic [31:0] q_q;
  logic        err_q;

  logic [31:0] mem [RamDepth];

  logic                  capture;
  logic                  do_access;
  logic                  ram_hit;
  logic                  mmio_hit;
  logic [ADDR_WIDTH-1:0] ram_idx;
  logic [31:0]           rd_data;
  logic                  rd_err;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      wait_cnt_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    capture    = 1'b0;
    do_access  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          capture    = 1'b1;
          wait_cnt_d = WaitLoad;
          state_d    = (WaitLoad == 4'd0) ? StAccess : StWait;
        end
      end
      StWait: begin
        // Spends exactly WaitLoad cycles here; <= guards against a zero count.
        wait_cnt_d = wait_cnt_q - 4'd1;
        if (wait_cnt_q <= 4'd1) begin
          state_d = StAccess;
        end
      end
      StAccess: begin
        do_access = 1'b1;
        state_d   = StResp;
      end
      StResp: begin
        // req is not sampled here; a held req is picked up again in idle.
        state_d = StIdle;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Address decode and read mux
  // ---------------------------------------------------------------------------
  assign ram_hit  = (addr_q >> ADDR_WIDTH) == '0;
  assign mmio_hit = (addr_q[29:28] == 2'b11);
  assign ram_idx  = addr_q[ADDR_WIDTH-1:0];

  always_comb begin
    rd_data = UNMAP_DATA;
    rd_err  = 1'b1;
    if (ram_hit) begin
      rd_data = mem[ram_idx];
      rd_err  = 1'b0;
    end else if (mmio_hit) begin
      case (addr_q[1:0])
        2'd0: begin
          rd_data = cycle_cnt_q;
          rd_err  = 1'b0;
        end
        2'd1: begin
          rd_data = led_reg_q;
          rd_err  = 1'b0;
        end
        2'd2: begin
          rd_data = scratch_q;
          rd_err  = 1'b0;
        end
        default: begin
          // Reserved slot answers like the unmapped region.
          rd_data = UNMAP_DATA;
          rd_err  = 1'b1;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Captured request, response registers and MMIO registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q    <= '0;
      wren_q    <= 1'b0;
      wdata_q   <= '0;
      q_q       <= '0;
      err_q     <= 1'b0;
      led_reg_q <= '0;
      scratch_q <= '0;
    end else begin
      if (capture) begin
        addr_q  <= address;
        wren_q  <= wren;
        wdata_q <= data;
      end
      if (do_access) begin
        err_q <= rd_err;
        // Writes return zero; only reads carry data back.
        q_q   <= wren_q ? 32'h0 : rd_data;
        if (wren_q && !ram_hit && mmio_hit) begin
          if (addr_q[1:0] == 2'd1) begin
            led_reg_q <= wdata_q;
          end
          if (addr_q[1:0] == 2'd2) begin
            scratch_q <= wdata_q;
          end
        end
      end
    end
  end

  // Free-running cycle counter; a read sees the value held before the access edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_q + 32'd1;
    end
  end

  // RAM contents survive reset; the reset gate keeps an interrupted write out.
  always_ff @(posedge clk) begin
    if (do_access && wren_q && ram_hit && !reset) begin
      mem[ram_idx] <= wdata_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign ready = (state_q == StResp);
  assign err   = ready & err_q;
  assign q     = q_q;
  assign led   = led_reg_q[7:0];

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed vector table, hand-written
// corner sequences and randomized traffic against a behavioural model.

module tb_mem_responder;

  localparam int          WS    = 1;
  localparam logic [31:0] UNMAP = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, wren;
  logic [29:0] address;
  logic [31:0] data;
  logic [31:0] q;
  logic        ready, err;
  logic [7:0]  led;

  logic        req0, wren0;
  logic [29:0] address0;
  logic [31:0] data0;
  logic [31:0] q0;
  logic        ready0, err0;
  logic [7:0]  led0;

  always #5 clk = ~clk;

  mem_responder #(
    .ADDR_WIDTH (10),
    .WAIT_STATES(WS),
    .UNMAP_DATA (UNMAP)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .wren   (wren),
    .address(address),
    .data   (data),
    .q      (q),
    .ready  (ready),
    .err    (err),
    .led    (led)
  );

  mem_responder #(
    .ADDR_WIDTH (10),
    .WAIT_STATES(0),
    .UNMAP_DATA (UNMAP)
  ) dut0 (
    .clk    (clk),
    .reset  (reset),
    .req    (req0),
    .wren   (wren0),
    .address(address0),
    .data   (data0),
    .q      (q0),
    .ready  (ready0),
    .err    (err0),
    .led    (led0)
  );

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int n_total = 0;
  int n_pass  = 0;

  // Behavioural model state
  logic [31:0] ram_m [1024];
  bit          known [1024];
  logic [31:0] led_m;
  logic [31:0] scratch_m;
  int          r_edge;  // last edge that sampled reset high

  typedef struct {
    logic        w;
    logic [29:0] a;
    logic [31:0] d;
    logic        chk_q;
    logic [31:0] eq;
    logic        ee;
    logic [7:0]  eled;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
  endtask

  // Expected result of an access whose access edge is acc_edge; updates model state.
  function automatic void model_apply(input logic w, input logic [29:0] a, input logic [31:0] d,
                                      input int acc_edge, output logic ck,
                                      output logic [31:0] eq, output logic ee);
    logic [31:0] ctr;
    ctr = 32'(acc_edge - 1 - r_edge);
    ck  = !w;
    eq  = UNMAP;
    ee  = 1'b1;
    if (a < 30'd1024) begin
      ee = 1'b0;
      if (w) begin
        ram_m[a[9:0]] = d;
        known[a[9:0]] = 1'b1;
        eq = 32'h0;
        ck = 1'b1;
      end else begin
        eq = ram_m[a[9:0]];
        ck = known[a[9:0]];
      end
    end else if (a[29:28] == 2'b11) begin
      case (int'(a % 30'd4))
        0: begin ee = 1'b0; eq = ctr; end
        1: begin ee = 1'b0; eq = led_m; if (w) led_m = d; end
        2: begin ee = 1'b0; eq = scratch_m; if (w) scratch_m = d; end
        default: begin ee = 1'b1; eq = UNMAP; end
      endcase
    end
  endfunction

  // One transaction on the WS=1 instance, started at a negedge with the DUT idle.
  // Returns at the negedge of the cycle after ready.
  task automatic txn(input logic w, input logic [29:0] a, input logic [31:0] d,
                     input bit scramble, output logic [31:0] q_o, output logic e_o,
                     output int acc_edge);
    int n0;
    int lat;
    bit got;
    req = 1'b1; wren = w; address = a; data = d;
    n0 = edge_cnt;
    lat = 0;
    got = 1'b0;
    for (int k = 1; k <= 40 && !got; k++) begin
      @(negedge clk);
      if (ready) begin
        got = 1'b1;
        lat = k;
      end else if (scramble) begin
        address = 30'($urandom);
        data    = $urandom;
        wren    = 1'($urandom);
      end
    end
    if (!got) begin
      n_total++;
      $display("FAIL ready_timeout: no ready within 40 cycles for address 0x%08h", a);
    end else begin
      chk("latency", 32'(lat), 32'(WS + 2));
    end
    q_o = q;
    e_o = err;
    acc_edge = n0 + lat;
    req = 1'b0;
    @(negedge clk);
    chk("ready_single_cycle", {31'h0, ready}, 32'h0);
  endtask

  function automatic logic [29:0] rand_addr();
    logic [29:0] a;
    int sel;
    sel = int'($urandom_range(0, 9));
    if (sel <= 3) a = 30'($urandom_range(0, 15));
    else if (sel == 4) a = 30'(1023 - $urandom_range(0, 3));
    else if (sel <= 6) a = {2'b11, 26'($urandom), 2'($urandom_range(0, 3))};
    else begin
      a = {2'($urandom_range(0, 2)), 28'($urandom)};
      if (a < 30'd1024) a = a + 30'd1024;
    end
    return a;
  endfunction

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    req = 1'b0;
    req0 = 1'b0;
    repeat (cycles) @(negedge clk);
    reset = 1'b0;
    r_edge = edge_cnt;
    led_m = 32'h0;
    scratch_m = 32'h0;
  endtask

  initial begin
    logic [31:0] gq, q1, q2, eq;
    logic        ge, ck, ee, seen;
    int          ae, ae2;
    vec_t        v;

    reset = 1'b1;
    req = 1'b0; wren = 1'b0; address = '0; data = '0;
    req0 = 1'b0; wren0 = 1'b0; address0 = '0; data0 = '0;
    for (int i = 0; i < 1024; i++) known[i] = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_ready", {31'h0, ready}, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    chk("rst_q", q, 32'h0);
    chk("rst_led", {24'h0, led}, 32'h0);
    chk("rst_ready0", {31'h0, ready0}, 32'h0);
    chk("rst_q0_led0_err0", {q0[22:0], err0, led0}, 32'h0);
    do_reset(1);

    // Directed vectors
    vecs.push_back('{1'b1, 30'h0000_0005, 32'h1234_5678, 1'b1, 32'h0,         1'b0, 8'h00});
    vecs.push_back('{1'b0, 30'h0000_0005, 32'h0,         1'b1, 32'h1234_5678, 1'b0, 8'h00});
    vecs.push_back('{1'b1, 30'h0000_0000, 32'h1111_1111, 1'b1, 32'h0,         1'b0, 8'h00});
    vecs.push_back('{1'b1, 30'h0000_03FF, 32'h0BAD_F00D, 1'b1, 32'h0,         1'b0, 8'h00});
    vecs.push_back('{1'b0, 30'h0000_03FF, 32'h0,         1'b1, 32'h0BAD_F00D, 1'b0, 8'h00});
    vecs.push_back('{1'b1, 30'h3000_0001, 32'h0000_01A5, 1'b0, 32'h0,         1'b0, 8'hA5});
    vecs.push_back('{1'b0, 30'h3000_0001, 32'h0,         1'b1, 32'h0000_01A5, 1'b0, 8'hA5});
    vecs.push_back('{1'b1, 30'h3000_0002, 32'hCAFE_F00D, 1'b0, 32'h0,         1'b0, 8'hA5});
    vecs.push_back('{1'b0, 30'h3000_0002, 32'h0,         1'b1, 32'hCAFE_F00D, 1'b0, 8'hA5});
    vecs.push_back('{1'b0, 30'h1000_0000, 32'h0,         1'b1, 32'hDEAD_BEEF, 1'b1, 8'hA5});
    vecs.push_back('{1'b1, 30'h1000_0000, 32'h5555_5555, 1'b0, 32'h0,         1'b1, 8'hA5});
    vecs.push_back('{1'b1, 30'h0000_0400, 32'h9999_9999, 1'b0, 32'h0,         1'b1, 8'hA5});
    vecs.push_back('{1'b0, 30'h0000_0400, 32'h0,         1'b1, 32'hDEAD_BEEF, 1'b1, 8'hA5});
    vecs.push_back('{1'b0, 30'h0000_0000, 32'h0,         1'b1, 32'h1111_1111, 1'b0, 8'hA5});
    vecs.push_back('{1'b0, 30'h0000_0005, 32'h0,         1'b1, 32'h1234_5678, 1'b0, 8'hA5});
    vecs.push_back('{1'b0, 30'h3000_0003, 32'h0,         1'b1, 32'hDEAD_BEEF, 1'b1, 8'hA5});
    vecs.push_back('{1'b1, 30'h3000_0003, 32'h7777_7777, 1'b0, 32'h0,         1'b1, 8'hA5});
    vecs.push_back('{1'b1, 30'h3000_0000, 32'h0,         1'b0, 32'h0,         1'b0, 8'hA5});
    vecs.push_back('{1'b1, 30'h3FFF_FFFD, 32'h0000_00C3, 1'b0, 32'h0,         1'b0, 8'hC3});
    vecs.push_back('{1'b0, 30'h3000_0001, 32'h0,         1'b1, 32'h0000_00C3, 1'b0, 8'hC3});

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      txn(v.w, v.a, v.d, 1'b0, gq, ge, ae);
      model_apply(v.w, v.a, v.d, ae, ck, eq, ee);
      if (v.chk_q) chk($sformatf("tbl%0d_q", i), gq, v.eq);
      chk($sformatf("tbl%0d_err", i), {31'h0, ge}, {31'h0, v.ee});
      chk($sformatf("tbl%0d_led", i), {24'h0, led}, {24'h0, v.eled});
    end

    // Counter read back-to-back, after an ignored counter write above.
    txn(1'b0, 30'h3000_0000, 32'h0, 1'b0, q1, ge, ae);
    model_apply(1'b0, 30'h3000_0000, 32'h0, ae, ck, eq, ee);
    chk("ctr_abs1", q1, eq);
    txn(1'b0, 30'h3000_0000, 32'h0, 1'b0, q2, ge, ae2);
    model_apply(1'b0, 30'h3000_0000, 32'h0, ae2, ck, eq, ee);
    chk("ctr_abs2", q2, eq);
    chk("ctr_delta", q2 - q1, 32'(WS + 3));

    // Reset during the wait of a write to A=7.
    txn(1'b1, 30'h7, 32'h0000_0007, 1'b0, gq, ge, ae);
    model_apply(1'b1, 30'h7, 32'h0000_0007, ae, ck, eq, ee);
    req = 1'b1; wren = 1'b1; address = 30'h7; data = 32'hFFFF_FFFF;
    @(negedge clk);
    seen = ready;
    reset = 1'b1;
    req = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seen = seen | ready;
    end
    reset = 1'b0;
    r_edge = edge_cnt;
    led_m = 32'h0;
    scratch_m = 32'h0;
    chk("abort_no_ready", {31'h0, seen}, 32'h0);
    chk("abort_led_reset", {24'h0, led}, 32'h0);
    txn(1'b0, 30'h7, 32'h0, 1'b0, gq, ge, ae);
    model_apply(1'b0, 30'h7, 32'h0, ae, ck, eq, ee);
    chk("abort_ram_kept", gq, eq);
    txn(1'b0, 30'h3000_0002, 32'h0, 1'b0, gq, ge, ae);
    model_apply(1'b0, 30'h3000_0002, 32'h0, ae, ck, eq, ee);
    chk("abort_scratch_reset", gq, eq);

    // Randomized traffic; inputs are scrambled during the wait on some transactions.
    for (int i = 0; i < 150; i++) begin
      logic        w;
      logic [29:0] a;
      logic [31:0] d;
      w = 1'($urandom_range(0, 1));
      a = rand_addr();
      d = $urandom;
      txn(w, a, d, bit'($urandom_range(0, 1)), gq, ge, ae);
      model_apply(w, a, d, ae, ck, eq, ee);
      if (ck) chk($sformatf("rnd%0d_q a=%08h", i, a), gq, eq);
      chk($sformatf("rnd%0d_err a=%08h", i, a), {31'h0, ge}, {31'h0, ee});
      chk($sformatf("rnd%0d_led", i), {24'h0, led}, {24'h0, led_m[7:0]});
    end

    // WAIT_STATES=0 instance: latency 2, held req gives one ready every 3 cycles.
    begin
      int          lat0, n_rdy, n_consec, since;
      logic        prev_rdy;
      logic [31:0] prev_q;
      req0 = 1'b1; wren0 = 1'b0; address0 = 30'h3000_0000; data0 = 32'h0;
      lat0 = 0;
      for (int k = 1; k <= 10 && lat0 == 0; k++) begin
        @(negedge clk);
        if (ready0) lat0 = k;
      end
      chk("ws0_latency", 32'(lat0), 32'd2);
      chk("ws0_err", {31'h0, err0}, 32'h0);
      prev_q = q0; prev_rdy = ready0; n_rdy = 0; n_consec = 0; since = 0;
      for (int k = 1; k <= 30; k++) begin
        @(negedge clk);
        since++;
        if (ready0) begin
          n_rdy++;
          if (prev_rdy) n_consec++;
          chk("ws0_spacing", 32'(since), 32'd3);
          chk("ws0_ctr_delta", q0 - prev_q, 32'd3);
          prev_q = q0;
          since = 0;
        end
        prev_rdy = ready0;
      end
      req0 = 1'b0;
      chk("ws0_ready_count", 32'(n_rdy), 32'd10);
      chk("ws0_consecutive", 32'(n_consec), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
